// File: rtl/prog_delay_pipe_pkg.sv
// Shared types and helpers for the programmable delay pipe.
package prog_delay_pkg;

    localparam int WIDTH_DEF         = 8;
    localparam int CHANNELS_DEF      = 2;
    localparam int MAX_DELAY_DEF     = 8;
    localparam int DEFAULT_DELAY_DEF = 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WARMUP = 1'b1
    } cfg_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] value;
    } clamp_t;

    // Bits needed to hold a latency value 0..max_delay.
    function automatic int dly_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Bits needed to select a channel; never narrower than one bit.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Force a requested latency into 1..max_delay and flag any correction.
    function automatic clamp_t clamp_delay(input logic [31:0] req, input logic [31:0] max_delay);
        clamp_t r;
        r.err   = 1'b0;
        r.value = req;
        if (req == 32'd0) begin
            r.value = 32'd1;
            r.err   = 1'b1;
        end else if (req > max_delay) begin
            r.value = max_delay;
            r.err   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_delay_pipe_if.sv
// Sample and configuration bundle between the driver side and the delay pipe.
interface prog_delay_pipe_if
    import prog_delay_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF
) ();

    localparam int CHAN_W = chan_width(CHANNELS);
    localparam int DLY_W  = dly_width(MAX_DELAY);

    logic [CHANNELS-1:0]            in_valid;
    logic [CHANNELS-1:0][WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]            out_valid;
    logic [CHANNELS-1:0][WIDTH-1:0] out_data;
    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [CHAN_W-1:0]              cfg_chan;
    logic [DLY_W-1:0]               cfg_delay;
    logic                           cfg_err;
    logic                           busy;

    modport master (
        output in_valid, in_data, cfg_valid, cfg_chan, cfg_delay,
        input  out_valid, out_data, cfg_ready, cfg_err, busy
    );

    modport slave (
        input  in_valid, in_data, cfg_valid, cfg_chan, cfg_delay,
        output out_valid, out_data, cfg_ready, cfg_err, busy
    );

endinterface

// File: rtl/prog_delay_pipe_chan.sv
// One channel of the delay pipe: shift stages, latency register, flush and output tap.
module prog_delay_chan #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 1,
    parameter int DLY_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load,
    input  logic [DLY_W-1:0] new_delay,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DLY_W-1:0]   delay;
    logic [MAX_DELAY:1] stage_valid;
    logic [WIDTH-1:0]   stage_data [1:MAX_DELAY];

    // Shift every cycle; a new latency flushes older stages but keeps this cycle's input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay       <= DLY_W'(DEFAULT_DELAY);
            stage_valid <= '0;
            for (int k = 1; k <= MAX_DELAY; k++) begin
                stage_data[k] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            stage_valid[1] <= in_valid;
            stage_data[1]  <= in_data;
            if (load) begin
                delay <= new_delay;
                for (int k = 2; k <= MAX_DELAY; k++) begin
                    stage_valid[k] <= 1'b0;
                    stage_data[k]  <= '0;
                end
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                for (int k = 2; k <= MAX_DELAY; k++) begin
                    stage_valid[k] <= stage_valid[k-1];
                    stage_data[k]  <= stage_data[k-1];
                end
                out_valid <= stage_valid[delay];
                out_data  <= stage_data[delay];
            end
        end
    end

endmodule

// File: rtl/prog_delay_pipe.sv
// Multi-channel delay pipe with per-channel runtime latency and a config handshake.
module prog_delay_pipe
    import prog_delay_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int CHANNELS      = CHANNELS_DEF,
    parameter int MAX_DELAY     = MAX_DELAY_DEF,
    parameter int DEFAULT_DELAY = DEFAULT_DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    prog_delay_pipe_if.slave bus
);

    localparam int DLY_W = dly_width(MAX_DELAY);

    cfg_state_e                     state;
    logic [DLY_W-1:0]               warm_cnt;
    clamp_t                         clamp_res;
    logic [DLY_W-1:0]               clamp_val;
    logic                           unused_clamp_bits;
    logic                           chan_ok;
    logic                           accept;
    logic [CHANNELS-1:0]            load;
    logic [CHANNELS-1:0]            out_valid_w;
    logic [CHANNELS-1:0][WIDTH-1:0] out_data_w;

    assign clamp_res         = clamp_delay(32'(bus.cfg_delay), 32'(MAX_DELAY));
    assign clamp_val         = clamp_res.value[DLY_W-1:0];
    assign unused_clamp_bits = ^clamp_res.value[31:DLY_W];
    assign chan_ok           = (32'(bus.cfg_chan) < 32'(CHANNELS));
    assign accept            = bus.cfg_valid && bus.cfg_ready;

    // Steer an accepted request to the addressed channel only when it exists.
    always_comb begin
        load = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept && chan_ok && (32'(bus.cfg_chan) == 32'(c))) begin
                load[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        prog_delay_chan #(
            .WIDTH         (WIDTH),
            .MAX_DELAY     (MAX_DELAY),
            .DEFAULT_DELAY (DEFAULT_DELAY),
            .DLY_W         (DLY_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (bus.in_valid[c]),
            .in_data   (bus.in_data[c]),
            .load      (load[c]),
            .new_delay (clamp_val),
            .out_valid (out_valid_w[c]),
            .out_data  (out_data_w[c])
        );
    end

    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;

    // Config FSM: accept in IDLE, then hold off further requests for the new latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            warm_cnt      <= '0;
            bus.cfg_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.cfg_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= WARMUP;
                        bus.cfg_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        warm_cnt      <= chan_ok ? (clamp_val - DLY_W'(1)) : '0;
                        if (clamp_res.err || !chan_ok) begin
                            bus.cfg_err <= 1'b1;
                        end
                    end
                end
                WARMUP: begin
                    if (warm_cnt == '0) begin
                        state         <= IDLE;
                        bus.cfg_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt - DLY_W'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.cfg_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
